// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter that is the sole writer of a shared register; optional grant hold under REG_ARB_LOCK_EN
module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*DATA_W-1:0]  data_i,
`ifdef REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         lock_i,
`endif
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic [DATA_W-1:0]          q_o,
  output logic                       wr_valid_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
`ifdef REG_ARB_LOCK_EN
  localparam logic [1:0] LOCK  = 2'd2;
`endif
  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d, owner_q, owner_d, win;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [DATA_W-1:0]  q_q, q_d;
  logic               hit, found;
`ifdef REG_ARB_LOCK_EN
  logic               wr_q, wr_d, hold;
`endif
  // first requester at or after ptr, wrapping past the top index
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = int'(ptr_q) + i;
      j = (j >= NUM_REQ) ? j - NUM_REQ : j;
      if (!found && req_i[j]) begin
        found = 1'b1;
        win = IW'(j);
      end
    end
  end
  // next-state: grant-and-load on a hit, otherwise clear strobe and hold
  always_comb begin
    hit = en_i & |req_i;
    state_d = hit ? GRANT : IDLE;
    gnt_d = hit ? NUM_REQ'(1) << win : '0;
    owner_d = hit ? win : owner_q;
    ptr_d = hit ? ((win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1) : ptr_q;
    q_d = hit ? data_i[int'(win)*DATA_W +: DATA_W] : q_q;
`ifdef REG_ARB_LOCK_EN
    wr_d = hit;
    hold = lock_i[owner_q];
    if (hit && lock_i[win]) state_d = LOCK;
    if (state_q == LOCK) begin
      state_d = hold ? LOCK : IDLE;
      gnt_d = hold ? gnt_q : '0;
      owner_d = owner_q;
      ptr_d = ptr_q;
      wr_d = hold & req_i[owner_q];
      q_d = wr_d ? data_i[int'(owner_q)*DATA_W +: DATA_W] : q_q;
    end
`endif
  end
  // state and output registers, reset dominates everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      gnt_q <= '0;
      q_q <= '0;
`ifdef REG_ARB_LOCK_EN
      wr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      gnt_q <= gnt_d;
      q_q <= q_d;
`ifdef REG_ARB_LOCK_EN
      wr_q <= wr_d;
`endif
    end
  end
  assign gnt_o = gnt_q;
  assign owner_o = owner_q;
  assign q_o = q_q;
`ifdef REG_ARB_LOCK_EN
  assign wr_valid_o = wr_q;
`else
  assign wr_valid_o = state_q == GRANT;
`endif
endmodule
